// File: rtl/perf_counter_bank.sv
// Bank of event counters with an APB register interface and atomic LO/HI reads via a per-counter HI shadow.
// Defining PERF_OVF_IRQ_EN adds the IRQ_MASK register at 0x008 and the registered ovf_irq output.
module perf_counter_bank #(
   parameter int NUM_COUNTERS  = 8,
   parameter int COUNTER_WIDTH = 48,
   parameter int NUM_EVENTS    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] events,
   input  logic [11:0]           paddr,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [31:0]           pwdata,
   output logic [31:0]           prdata,
   output logic                  pready,
   output logic                  pslverr
`ifdef PERF_OVF_IRQ_EN
   ,
   output logic                  ovf_irq
`endif
);
   localparam int HW = COUNTER_WIDTH - 32;

   logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_COUNTERS-1:0][HW-1:0]            shadow_q, shadow_d;
   logic [NUM_COUNTERS-1:0][4:0]               evsel_q, evsel_d;
   logic [NUM_COUNTERS-1:0]                    cnt_en_q, cnt_en_d;
   logic [NUM_COUNTERS-1:0]                    ovf_q, ovf_d;
   logic                                       en_q, en_d;
   logic [31:0]                                prdata_q, prdata_d;
   logic                                       pready_q, pready_d;
   logic                                       pslverr_q, pslverr_d;
`ifdef PERF_OVF_IRQ_EN
   logic [NUM_COUNTERS-1:0]                    mask_q, mask_d;
   logic                                       irq_q, irq_d;
`endif

   logic                    acc, rd, wr, err, clear_all, in_cnt, idx_ok;
   logic [NUM_COUNTERS-1:0] w1c, lo_rd, inc, ovf_set;
   logic [31:0]             rdata, ev_pad;
   logic                    unused_pwdata;

   assign unused_pwdata = ^pwdata;

   // Register decode; an access is taken once, on the first cycle of psel&penable.
   always_comb begin
      acc       = psel & penable & ~pready_q;
      rd        = acc & ~pwrite;
      wr        = acc & pwrite;
      err       = 1'b0;
      clear_all = 1'b0;
      rdata     = '0;
      w1c       = '0;
      lo_rd     = '0;
      en_d      = en_q;
      evsel_d   = evsel_q;
      cnt_en_d  = cnt_en_q;
`ifdef PERF_OVF_IRQ_EN
      mask_d    = mask_q;
`endif
      in_cnt    = (paddr[11:8] == 4'h1);
      idx_ok    = ({28'd0, paddr[7:4]} < 32'(NUM_COUNTERS));
      if (acc) begin
         if (paddr == 12'h000) begin
            rdata = {31'd0, en_q};
            if (wr) begin
               en_d      = pwdata[0];
               clear_all = pwdata[1];
            end
         end else if (paddr == 12'h004) begin
            rdata = 32'(ovf_q);
            if (wr) w1c = pwdata[NUM_COUNTERS-1:0];
         end
`ifdef PERF_OVF_IRQ_EN
         else if (paddr == 12'h008) begin
            rdata = 32'(mask_q);
            if (wr) mask_d = pwdata[NUM_COUNTERS-1:0];
         end
`endif
         else if (in_cnt && idx_ok && paddr[3:0] == 4'h0) begin
            if (wr && {27'd0, pwdata[4:0]} >= 32'(NUM_EVENTS)) begin
               err = 1'b1;
            end else begin
               for (int i = 0; i < NUM_COUNTERS; i++) begin
                  if (paddr[7:4] == 4'(i)) begin
                     rdata = {23'd0, cnt_en_q[i], 3'd0, evsel_q[i]};
                     if (wr) begin
                        evsel_d[i]  = pwdata[4:0];
                        cnt_en_d[i] = pwdata[8];
                     end
                  end
               end
            end
         end else if (in_cnt && idx_ok && paddr[3:0] == 4'h4 && !pwrite) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
               if (paddr[7:4] == 4'(i)) begin
                  rdata    = cnt_q[i][31:0];
                  lo_rd[i] = 1'b1;
               end
            end
         end else if (in_cnt && idx_ok && paddr[3:0] == 4'h8 && !pwrite) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
               if (paddr[7:4] == 4'(i)) rdata = 32'(shadow_q[i]);
            end
         end else begin
            err = 1'b1;
         end
      end
      pready_d  = acc;
      pslverr_d = acc & err;
      prdata_d  = (rd && !err) ? rdata : 32'd0;
   end

   // Counting; clear-all beats a same-edge increment, and a new overflow beats a same-edge W1C.
   always_comb begin
      ev_pad                 = '0;
      ev_pad[NUM_EVENTS-1:0] = events;
      cnt_d                  = cnt_q;
      shadow_d               = shadow_q;
      inc                    = '0;
      ovf_set                = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         inc[i] = en_q & cnt_en_q[i] & ev_pad[evsel_q[i]];
         if (clear_all) begin
            cnt_d[i] = '0;
         end else if (inc[i]) begin
            cnt_d[i]   = cnt_q[i] + COUNTER_WIDTH'(1);
            ovf_set[i] = &cnt_q[i];
         end
         if (lo_rd[i]) shadow_d[i] = cnt_q[i][COUNTER_WIDTH-1:32];
      end
      ovf_d = (ovf_q & ~w1c) | ovf_set;
`ifdef PERF_OVF_IRQ_EN
      irq_d = |(ovf_q & mask_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         shadow_q  <= '0;
         evsel_q   <= '0;
         cnt_en_q  <= '0;
         ovf_q     <= '0;
         en_q      <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef PERF_OVF_IRQ_EN
         mask_q    <= '0;
         irq_q     <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         evsel_q   <= evsel_d;
         cnt_en_q  <= cnt_en_d;
         ovf_q     <= ovf_d;
         en_q      <= en_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
`ifdef PERF_OVF_IRQ_EN
         mask_q    <= mask_d;
         irq_q     <= irq_d;
`endif
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;
`ifdef PERF_OVF_IRQ_EN
   assign ovf_irq = irq_q;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (COUNTER_WIDTH=33); counter preloads use force on the counter array.
`timescale 1ns/1ps
module tb_perf_counter_bank;
   localparam int NC = 8;
   localparam int CW = 33;
   localparam int NE = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [NE-1:0] events;
   logic [11:0]   paddr;
   logic          psel, penable, pwrite;
   logic [31:0]   pwdata, prdata;
   logic          pready, pslverr;
`ifdef PERF_OVF_IRQ_EN
   logic          ovf_irq;
`endif

   int                   errors = 0;
   int                   checks = 0;
   logic [NE-1:0]        acc_ev;
   logic                 irq_snap;
   logic [CW-1:0]        exp_cnt [NC];
   logic [NC-1:0][CW-1:0] pre;
   logic [31:0]          d;
   logic                 e;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW), .NUM_EVENTS(NE)) dut (
      .clk     (clk),
      .rst     (rst),
      .events  (events),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
`ifdef PERF_OVF_IRQ_EN
      ,
      .ovf_irq (ovf_irq)
`endif
   );

   function automatic logic [11:0] evsel_a(input int i);
      return 12'(12'h100 + 16 * i);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One APB transfer starting at a negedge; acc_ev is driven only across the access edge.
   task automatic apb(input string tag, input logic [11:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic rerr);
      int waits;
      paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      events  = acc_ev;
      @(negedge clk);
      events = '0;
      acc_ev = '0;
      waits  = 0;
      while (pready !== 1'b1 && waits < 4) begin
         @(negedge clk);
         waits++;
      end
      check({tag, " wait states"}, 64'(waits), 64'd0);
      rdat = prdata;
      rerr = pslverr;
`ifdef PERF_OVF_IRQ_EN
      irq_snap = ovf_irq;
`endif
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      check({tag, " pready drop"}, 64'(pready), 64'd0);
      check({tag, " prdata idle"}, 64'(prdata), 64'd0);
   endtask

   task automatic do_rd(input string tag, input logic [11:0] a, input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] rdat;
      logic        rerr;
      apb(tag, a, 1'b0, 32'd0, rdat, rerr);
      check({tag, " prdata"}, 64'(rdat), 64'(exp_d));
      check({tag, " pslverr"}, 64'(rerr), 64'(exp_e));
   endtask

   task automatic do_wr(input string tag, input logic [11:0] a, input logic [31:0] wd, input logic exp_e);
      logic [31:0] rdat;
      logic        rerr;
      apb(tag, a, 1'b1, wd, rdat, rerr);
      check({tag, " pslverr"}, 64'(rerr), 64'(exp_e));
   endtask

   task automatic pulse(input int bit_idx, input int n);
      events[bit_idx] = 1'b1;
      repeat (n) @(negedge clk);
      events = '0;
   endtask

   // Forced across one posedge so the flops themselves capture the preset value.
   task preload(input int idx, input logic [CW-1:0] v);
      exp_cnt[idx] = v;
      for (int i = 0; i < NC; i++) pre[i] = exp_cnt[i];
      force dut.cnt_q = pre;
      @(negedge clk);
      release dut.cnt_q;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; events = '0; paddr = '0; psel = 1'b0; penable = 1'b0;
      pwrite = 1'b0; pwdata = '0; acc_ev = '0; irq_snap = 1'b0;
      for (int i = 0; i < NC; i++) exp_cnt[i] = '0;
      repeat (3) @(negedge clk);
      check("reset pready", 64'(pready), 64'd0);
      check("reset prdata", 64'(prdata), 64'd0);
      check("reset pslverr", 64'(pslverr), 64'd0);
`ifdef PERF_OVF_IRQ_EN
      check("reset ovf_irq", 64'(ovf_irq), 64'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      do_rd("rst ctrl", 12'h000, 32'd0, 1'b0);
      do_rd("rst ovf", 12'h004, 32'd0, 1'b0);
      do_rd("rst lo0", 12'h104, 32'd0, 1'b0);

      // Basic event counting on counter 0, event 3.
      do_wr("ctrl en", 12'h000, 32'h1, 1'b0);
      do_wr("evsel0", evsel_a(0), 32'h103, 1'b0);
      do_rd("evsel0 rb", evsel_a(0), 32'h103, 1'b0);
      pulse(3, 10);
      exp_cnt[0] = 33'd10;
      do_rd("count lo0", 12'h104, 32'd10, 1'b0);
      do_rd("count hi0", 12'h108, 32'd0, 1'b0);

      // Atomic read: HI returns the shadow captured by the LO read.
      do_wr("evsel1", evsel_a(1), 32'h105, 1'b0);
      preload(1, 33'h1_FFFF_FFFF);
      do_rd("atomic lo1", 12'h114, 32'hFFFF_FFFF, 1'b0);
      pulse(5, 1);
      exp_cnt[1] = 33'd0;
      do_rd("atomic hi1 shadow", 12'h118, 32'h1, 1'b0);
      do_rd("atomic lo1 wrapped", 12'h114, 32'd0, 1'b0);
      do_rd("atomic hi1 new", 12'h118, 32'd0, 1'b0);
      do_rd("ovf bit1", 12'h004, 32'h2, 1'b0);
      do_wr("ovf w1c bit1", 12'h004, 32'h2, 1'b0);
      do_rd("ovf cleared", 12'h004, 32'h0, 1'b0);

      // Overflow wrap, then W1C colliding with a fresh overflow.
      do_wr("evsel2", evsel_a(2), 32'h107, 1'b0);
      preload(2, 33'h1_FFFF_FFFF);
      pulse(7, 1);
      exp_cnt[2] = 33'd0;
      do_rd("wrap lo2", 12'h124, 32'd0, 1'b0);
      do_rd("ovf bit2", 12'h004, 32'h4, 1'b0);
      preload(2, 33'h1_FFFF_FFFF);
      acc_ev = 16'h0080;
      do_wr("w1c vs set", 12'h004, 32'h4, 1'b0);
      exp_cnt[2] = 33'd0;
      do_rd("ovf set wins", 12'h004, 32'h4, 1'b0);
      do_rd("wrap lo2 again", 12'h124, 32'd0, 1'b0);

      // A LO read on a counting edge returns the pre-increment value.
      acc_ev = 16'h0008;
      do_rd("lo0 during inc", 12'h104, 32'd10, 1'b0);
      do_rd("lo0 after inc", 12'h104, 32'd11, 1'b0);

      // Global enable gates counting.
      do_wr("ctrl off", 12'h000, 32'h0, 1'b0);
      pulse(3, 3);
      do_rd("lo0 disabled", 12'h104, 32'd11, 1'b0);
      do_wr("ctrl on", 12'h000, 32'h1, 1'b0);

      // Clear-all with events active on the clearing edge.
      do_wr("evsel3", evsel_a(3), 32'h100, 1'b0);
      pulse(0, 4);
      do_rd("lo3 count", 12'h134, 32'd4, 1'b0);
      acc_ev = 16'h0009;
      do_wr("clear all", 12'h000, 32'h3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_rd($sformatf("clr lo%0d", i), 12'(12'h104 + 16 * i), 32'd0, 1'b0);
         exp_cnt[i] = '0;
      end
      do_rd("ctrl after clear", 12'h000, 32'h1, 1'b0);
      do_rd("ovf kept by clear", 12'h004, 32'h4, 1'b0);
      do_wr("ovf w1c bit2", 12'h004, 32'h4, 1'b0);
      do_rd("ovf zero", 12'h004, 32'h0, 1'b0);

      // Error responses leave state untouched.
      do_wr("evsel sel 0x1F", evsel_a(0), 32'h1F, 1'b1);
      do_rd("evsel0 kept", evsel_a(0), 32'h103, 1'b0);
      do_wr("evsel sel 16", evsel_a(4), 32'h110, 1'b1);
      do_rd("evsel4 kept", evsel_a(4), 32'h0, 1'b0);
      do_wr("evsel sel 15", evsel_a(4), 32'h10F, 1'b0);
      do_rd("evsel4 sel 15", evsel_a(4), 32'h10F, 1'b0);
      do_rd("idx 15", 12'h1F0, 32'd0, 1'b1);
      do_rd("idx 8", 12'h184, 32'd0, 1'b1);
      do_wr("wr lo0", 12'h104, 32'h5, 1'b1);
      do_wr("wr hi0", 12'h108, 32'h5, 1'b1);
      do_rd("lo0 kept", 12'h104, 32'd0, 1'b0);
      do_rd("unmapped 0x00C", 12'h00C, 32'd0, 1'b1);
      do_rd("unmapped 0x10C", 12'h10C, 32'd0, 1'b1);
`ifndef PERF_OVF_IRQ_EN
      do_rd("0x008 unmapped", 12'h008, 32'd0, 1'b1);
      do_wr("0x008 wr unmapped", 12'h008, 32'h1, 1'b1);
`else
      // Interrupt follows OVF_STATUS & IRQ_MASK one cycle late.
      do_wr("irq mask", 12'h008, 32'h1, 1'b0);
      do_rd("irq mask rb", 12'h008, 32'h1, 1'b0);
      preload(0, 33'h1_FFFF_FFFF);
      events[3] = 1'b1;
      @(negedge clk);
      events = '0;
      check("irq not yet", 64'(ovf_irq), 64'd0);
      @(negedge clk);
      check("irq raised", 64'(ovf_irq), 64'd1);
      exp_cnt[0] = '0;
      do_wr("irq w1c", 12'h004, 32'h1, 1'b0);
      check("irq held at w1c", 64'(irq_snap), 64'd1);
      check("irq dropped", 64'(ovf_irq), 64'd0);
`endif

      // Reset landing on the access edge abandons the transfer.
      paddr = 12'h000; pwrite = 1'b1; pwdata = 32'h0; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      check("mid-reset no pready", 64'(pready), 64'd0);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post-reset no pready", 64'(pready), 64'd0);
      do_rd("post-reset ctrl", 12'h000, 32'd0, 1'b0);
      do_rd("post-reset evsel0", evsel_a(0), 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
